// File: rtl/timer_pkg.sv
// Shared timer state encoding, also used by the display timing blocks.
// Types only; no logic, no latency.
`timescale 1ns/1ps
package timer_pkg;
    typedef enum logic [0:0] {TMR_IDLE, TMR_RUN} tmr_state_t;
endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot/periodic reload and a registered 1-cycle terminal pulse.
// Load takes effect on the accepting edge; tc rises on the (N+1)th enabled edge; load_ready is low in RUN or while stop is high.
`timescale 1ns/1ps
module down_timer
    import timer_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                enable,
    input  logic                stop,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_BITS-1:0] load_value,
    input  logic                periodic,
    output logic [NUM_BITS-1:0] count,
    output logic                busy,
    output logic                tc
);

    tmr_state_t          state_q, state_d;
    logic [NUM_BITS-1:0] count_q, count_d;
    logic [NUM_BITS-1:0] reload_q, reload_d;
    logic                mode_q, mode_d;
    logic                tc_q, tc_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        mode_d     = mode_q;
        tc_d       = 1'b0;
        load_ready = (state_q == TMR_IDLE) && !stop;

        // stop outranks both a pending load and the terminal event
        if (stop) begin
            state_d = TMR_IDLE;
            count_d = '0;
        end else if (state_q == TMR_IDLE) begin
            if (load_valid) begin
                count_d  = load_value;
                reload_d = load_value;
                mode_d   = periodic;
                state_d  = TMR_RUN;
            end
        end else if (enable) begin
            if (count_q != '0) begin
                count_d = count_q - NUM_BITS'(1);
            end else begin
                tc_d = 1'b1;
                if (mode_q) begin
                    count_d = reload_q;
                end else begin
                    state_d = TMR_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= TMR_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == TMR_RUN);
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: stimulus pushes hand-computed per-cycle expectations,
// a monitor pops them and compares against the DUT outputs.
`timescale 1ns/1ps
module tb_down_timer;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       enable = 1'b0;
    logic       stop = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_value = 8'd0;
    logic       periodic = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       tc;

    down_timer #(.NUM_BITS(8)) dut (
        .clk        (clk),
        .areset     (areset),
        .enable     (enable),
        .stop       (stop),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .periodic   (periodic),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    always #1 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       busy;
        logic       rdy;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;
    event chk_ev;

    task automatic cmp(input string nm, input int tag, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s test%0d t=%0t: got %0d, expected %0d", nm, tag, $time, act, req);
        end
    endtask

    // Monitor: compares at every falling edge, or on demand for between-edge checks.
    always begin
        @(negedge clk or chk_ev);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("count",      e.tag, count,             e.cnt);
            cmp("tc",         e.tag, {7'd0, tc},         {7'd0, e.tc});
            cmp("busy",       e.tag, {7'd0, busy},       {7'd0, e.busy});
            cmp("load_ready", e.tag, {7'd0, load_ready}, {7'd0, e.rdy});
        end
    end

    task automatic push(input logic [7:0] c, input logic t, input logic b, input logic r);
        exp_t e;
        e.cnt = c; e.tc = t; e.busy = b; e.rdy = r; e.tag = phase;
        sb.push_back(e);
    endtask

    // One clock: expectation applies to the state after the coming rising edge.
    task automatic step(input logic [7:0] c, input logic t, input logic b, input logic r);
        @(posedge clk);
        push(c, t, b, r);
        @(negedge clk);
        #0.5;
    endtask

    initial begin
        // 1: reset and idle hold
        phase = 1;
        for (int i = 0; i < 5; i++) step(8'd0, 1'b0, 1'b0, 1'b1);
        areset = 1'b0;
        for (int i = 0; i < 20; i++) step(8'd0, 1'b0, 1'b0, 1'b1);

        // 2: one-shot N=5
        phase = 2;
        load_valid = 1'b1; load_value = 8'd5; periodic = 1'b0; enable = 1'b1;
        step(8'd5, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        for (int c = 4; c >= 0; c--) step(8'(c), 1'b0, 1'b1, 1'b0);
        step(8'd0, 1'b1, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;

        // 3: periodic N=3, 20 enabled edges, then stop
        phase = 3;
        load_valid = 1'b1; load_value = 8'd3; periodic = 1'b1; enable = 1'b1;
        step(8'd3, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k % 4 == 0) step(8'd3, 1'b1, 1'b1, 1'b0);
            else            step(8'(3 - (k % 4)), 1'b0, 1'b1, 1'b0);
        end
        stop = 1'b1;
        step(8'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        step(8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;

        // 4: pause at count=2
        phase = 4;
        load_valid = 1'b1; load_value = 8'd6; periodic = 1'b0; enable = 1'b1;
        step(8'd6, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        for (int c = 5; c >= 2; c--) step(8'(c), 1'b0, 1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step(8'd2, 1'b0, 1'b1, 1'b0);
        enable = 1'b1;
        step(8'd1, 1'b0, 1'b1, 1'b0);
        step(8'd0, 1'b0, 1'b1, 1'b0);
        step(8'd0, 1'b1, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b0, 1'b1);

        // 5: abort at count=4 with a competing load, then N=0 one-shot and periodic
        phase = 5;
        load_valid = 1'b1; load_value = 8'd7; periodic = 1'b0;
        step(8'd7, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        for (int c = 6; c >= 4; c--) step(8'(c), 1'b0, 1'b1, 1'b0);
        stop = 1'b1; load_valid = 1'b1; load_value = 8'd9;
        step(8'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0; load_valid = 1'b0;
        step(8'd0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b1; load_value = 8'd0; periodic = 1'b0;
        step(8'd0, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        step(8'd0, 1'b1, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b1; periodic = 1'b1;
        step(8'd0, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(8'd0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step(8'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        // 6: asynchronous reset between edges at count=6
        phase = 6;
        load_valid = 1'b1; load_value = 8'd8; periodic = 1'b0;
        step(8'd8, 1'b0, 1'b1, 1'b0);
        load_valid = 1'b0;
        step(8'd7, 1'b0, 1'b1, 1'b0);
        step(8'd6, 1'b0, 1'b1, 1'b0);
        areset = 1'b1;
        #0.2;
        push(8'd0, 1'b0, 1'b0, 1'b1);
        ->chk_ev;
        #0.1;
        step(8'd0, 1'b0, 1'b0, 1'b1);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) step(8'd0, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;

        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
